// File: rtl/date_calendar_counter_if.sv
// Date counter bus: strobes and edit requests in,
// calendar state and carries out.
interface date_calendar_counter_if;
   logic       eod;
   logic       inc_d;
   logic       dec_d;
   logic       inc_m;
   logic       dec_m;
   logic       inc_y;
   logic       dec_y;
   logic [5:0] day;
   logic [3:0] month;
   logic [13:0] year;
   logic       leap;
   logic [5:0] dim;
   logic       c_month;
   logic       c_year;

   modport master (
      output eod, inc_d, dec_d,
      output inc_m, dec_m, inc_y, dec_y,
      input  day, month, year, leap, dim,
      input  c_month, c_year
   );

   modport slave (
      input  eod, inc_d, dec_d,
      input  inc_m, dec_m, inc_y, dec_y,
      output day, month, year, leap, dim,
      output c_month, c_year
   );
endinterface

// File: rtl/date_calendar_counter.sv
// Calendar date counter: day/month/year chain with
// Gregorian leap handling via running year residues.
module date_calendar_counter #(
   parameter int RESET_YEAR = 2000
) (
   input logic clk,
   input logic rst,
   date_calendar_counter_if.slave bus
);

   localparam logic [13:0] L_RST_Y   = 14'(RESET_YEAR);
   localparam logic [1:0]  L_RST_M4  = 2'(RESET_YEAR % 4);
   localparam logic [6:0]  L_RST_M100 = 7'(RESET_YEAR % 100);
   localparam logic [8:0]  L_RST_M400 = 9'(RESET_YEAR % 400);

   logic [5:0]  r_day;
   logic [3:0]  r_month;
   logic [13:0] r_year;
   logic [1:0]  r_m4;
   logic [6:0]  r_m100;
   logic [8:0]  r_m400;

   logic        w_leap;
   logic [5:0]  w_dim;
   logic        w_at_end;
   logic        w_clamp;
   logic        w_c_month;
   logic        w_c_year;
   logic        w_m_edit;
   logic        w_y_edit;
   logic        w_d_ok;
   logic        w_m_up;
   logic        w_m_dn;
   logic        w_y_up;
   logic        w_y_dn;
   logic [5:0]  w_day_nxt;

   // Leap flag from residues; 10000 is a multiple of
   // 400 so the 9999<->0 wrap keeps residues coherent.
   always_comb begin
      w_leap = (r_m4 == 2'd0) &&
               ((r_m100 != 7'd0) || (r_m400 == 9'd0));
   end

   // Days-in-month decoder; unknown months read as 31.
   always_comb begin
      case (r_month)
         4'd4, 4'd6, 4'd9, 4'd11: w_dim = 6'd30;
         4'd2:    w_dim = w_leap ? 6'd29 : 6'd28;
         default: w_dim = 6'd31;
      endcase
   end

   // Carry chain and per-field request qualification.
   always_comb begin
      w_at_end  = (r_day == w_dim);
      w_clamp   = (r_day > w_dim);
      w_c_month = bus.eod & w_at_end;
      w_c_year  = w_c_month & (r_month == 4'd12);
      w_m_edit  = ~w_c_month & (bus.inc_m ^ bus.dec_m);
      w_y_edit  = ~w_c_year & (bus.inc_y ^ bus.dec_y);
      // A same-cycle month/year edit leaves the day
      // alone so the clamp sees the new month length.
      w_d_ok    = ~w_m_edit & ~w_y_edit;
      w_m_up    = w_c_month |
                  (bus.inc_m & ~bus.dec_m);
      w_m_dn    = ~w_c_month &
                  bus.dec_m & ~bus.inc_m;
      w_y_up    = w_c_year |
                  (bus.inc_y & ~bus.dec_y);
      w_y_dn    = ~w_c_year &
                  bus.dec_y & ~bus.inc_y;
   end

   // Day next state: clamp, then auto, then manual.
   always_comb begin
      w_day_nxt = r_day;
      if (w_clamp) begin
         w_day_nxt = w_dim;
      end else if (bus.eod) begin
         w_day_nxt = w_at_end ? 6'd1 : r_day + 6'd1;
      end else if (w_d_ok & bus.inc_d & ~bus.dec_d) begin
         w_day_nxt = w_at_end ? 6'd1 : r_day + 6'd1;
      end else if (w_d_ok & bus.dec_d & ~bus.inc_d) begin
         w_day_nxt = (r_day <= 6'd1) ? w_dim
                                     : r_day - 6'd1;
      end
   end

   // Day register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_day <= 6'd1;
      end else begin
         r_day <= w_day_nxt;
      end
   end

   // Month register, wrapping 1..12.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_month <= 4'd1;
      end else if (w_m_up) begin
         r_month <= (r_month >= 4'd12) ? 4'd1
                                      : r_month + 4'd1;
      end else if (w_m_dn) begin
         r_month <= (r_month <= 4'd1) ? 4'd12
                                     : r_month - 4'd1;
      end
   end

   // Year register, wrapping 0..9999.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_year <= L_RST_Y;
      end else if (w_y_up) begin
         r_year <= (r_year >= 14'd9999) ? 14'd0
                                       : r_year + 14'd1;
      end else if (w_y_dn) begin
         r_year <= (r_year == 14'd0) ? 14'd9999
                                    : r_year - 14'd1;
      end
   end

   // Year residues mod 4/100/400 tracking the year.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m4   <= L_RST_M4;
         r_m100 <= L_RST_M100;
         r_m400 <= L_RST_M400;
      end else if (w_y_up) begin
         r_m4   <= r_m4 + 2'd1;
         r_m100 <= (r_m100 >= 7'd99) ? 7'd0
                                    : r_m100 + 7'd1;
         r_m400 <= (r_m400 >= 9'd399) ? 9'd0
                                     : r_m400 + 9'd1;
      end else if (w_y_dn) begin
         r_m4   <= r_m4 - 2'd1;
         r_m100 <= (r_m100 == 7'd0) ? 7'd99
                                   : r_m100 - 7'd1;
         r_m400 <= (r_m400 == 9'd0) ? 9'd399
                                   : r_m400 - 9'd1;
      end
   end

   assign bus.day     = r_day;
   assign bus.month   = r_month;
   assign bus.year    = r_year;
   assign bus.leap    = w_leap;
   assign bus.dim     = w_dim;
   assign bus.c_month = w_c_month;
   assign bus.c_year  = w_c_year;

endmodule

// File: tb/tb_date_calendar_counter.sv
// Directed bench for date_calendar_counter with a
// reference calendar model and expected-value queue.
module tb_date_calendar_counter;

   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] EOD  = 7'b1000000;
   localparam logic [6:0] INCD = 7'b0100000;
   localparam logic [6:0] DECD = 7'b0010000;
   localparam logic [6:0] INCM = 7'b0001000;
   localparam logic [6:0] DECM = 7'b0000100;
   localparam logic [6:0] INCY = 7'b0000010;
   localparam logic [6:0] DECY = 7'b0000001;

   logic clk = 1'b0;
   logic rst = 1'b1;

   date_calendar_counter_if bus ();

   date_calendar_counter #(.RESET_YEAR(2000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int md = 1;
   int mm = 1;
   int my = 2000;
   string cur_tag = "reset";

   typedef struct {
      string       tag;
      logic [30:0] val;
   } exp_t;

   exp_t sb[$];

   function automatic bit f_leap(input int y);
      return (y % 4 == 0) &&
             ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int f_dim(input int m,
                                input int y);
      if (m == 2) return f_leap(y) ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11)
         return 30;
      return 31;
   endfunction

   function automatic logic [30:0] pack(input int d,
                                        input int m,
                                        input int y);
      logic [5:0]  pd;
      logic [3:0]  pm;
      logic [13:0] py;
      logic [5:0]  pdim;
      pd   = 6'(d);
      pm   = 4'(m);
      py   = 14'(y);
      pdim = 6'(f_dim(m, y));
      return {pd, pm, py, f_leap(y), pdim};
   endfunction

   function automatic logic [30:0] obs_date();
      return {bus.day, bus.month, bus.year,
              bus.leap, bus.dim};
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic [6:0] v);
      int  dv;
      bit  cm, cy, me, ye;
      int  nd, nm, ny;
      dv = f_dim(mm, my);
      cm = v[6] && (md == dv);
      cy = cm && (mm == 12);
      me = !cm && (v[3] != v[2]);
      ye = !cy && (v[1] != v[0]);
      if (cy || (v[1] && !v[0])) ny = (my + 1) % 10000;
      else if (v[0] && !v[1]) ny = (my + 9999) % 10000;
      else ny = my;
      if (cm || (v[3] && !v[2])) nm = (mm % 12) + 1;
      else if (v[2] && !v[3]) nm = (mm == 1) ? 12 : mm - 1;
      else nm = mm;
      if (md > dv) nd = dv;
      else if (v[6]) nd = cm ? 1 : md + 1;
      else if (!me && !ye && v[5] && !v[4])
         nd = (md == dv) ? 1 : md + 1;
      else if (!me && !ye && v[4] && !v[5])
         nd = (md == 1) ? dv : md - 1;
      else nd = md;
      md = nd;
      mm = nm;
      my = ny;
   endtask

   task automatic drive(input logic [6:0] v);
      bus.eod   = v[6];
      bus.inc_d = v[5];
      bus.dec_d = v[4];
      bus.inc_m = v[3];
      bus.dec_m = v[2];
      bus.inc_y = v[1];
      bus.dec_y = v[0];
   endtask

   // One clock with the given requests; carries are
   // checked before the edge, the date after it.
   task automatic tick(input logic [6:0] v);
      int   dv;
      logic xcm, xcy;
      exp_t e;
      drive(v);
      #1;
      dv  = f_dim(mm, my);
      xcm = v[6] && (md == dv);
      xcy = xcm && (mm == 12);
      chk({cur_tag, ".c_month"}, 32'(bus.c_month),
          32'(xcm));
      chk({cur_tag, ".c_year"}, 32'(bus.c_year),
          32'(xcy));
      model_step(v);
      sb.push_back('{cur_tag, pack(md, mm, my)});
      @(posedge clk);
      #1;
      drive(NONE);
      e = sb.pop_front();
      chk({e.tag, ".date"}, 32'(obs_date()),
          32'(e.val));
   endtask

   task automatic set_date(input int d, input int m,
                           input int y);
      while (my != y) tick((y > my) ? INCY : DECY);
      while (mm != m) tick((m > mm) ? INCM : DECM);
      while (md != d) tick((d > md) ? INCD : DECD);
   endtask

   initial begin
      drive(NONE);
      repeat (3) @(posedge clk);
      #1;
      cur_tag = "reset_held";
      chk(cur_tag, 32'(obs_date()),
          32'(pack(1, 1, 2000)));
      rst = 1'b0;
      #1;
      cur_tag = "reset_rel";
      chk(cur_tag, 32'(obs_date()),
          {1'b0, 6'd1, 4'd1, 14'd2000, 1'b1, 6'd31});
      chk("reset_carry",
          32'({bus.c_month, bus.c_year}), 32'd0);

      cur_tag = "preload";
      set_date(28, 2, 2023);
      cur_tag = "feb2023";
      tick(EOD);
      chk("mar1_2023", 32'({bus.day, bus.month, bus.year}),
          32'({6'd1, 4'd3, 14'd2023}));

      cur_tag = "preload";
      set_date(28, 2, 2024);
      chk("leap2024", 32'({bus.leap, bus.dim}),
          32'({1'b1, 6'd29}));
      cur_tag = "feb2024a";
      tick(EOD);
      chk("feb29_2024", 32'({bus.day, bus.month}),
          32'({6'd29, 4'd2}));
      cur_tag = "feb2024b";
      tick(EOD);
      chk("mar1_2024", 32'({bus.day, bus.month}),
          32'({6'd1, 4'd3}));

      cur_tag = "preload";
      set_date(31, 12, 2024);
      cur_tag = "yearwrap";
      tick(EOD);
      chk("jan1_2025",
          32'({bus.day, bus.month, bus.year, bus.leap}),
          32'({6'd1, 4'd1, 14'd2025, 1'b0}));

      cur_tag = "preload";
      set_date(1, 1, 2023);
      cur_tag = "fullrun";
      for (int i = 0; i < 731; i++) tick(EOD);
      chk("fullrun_end",
          32'({bus.day, bus.month, bus.year}),
          32'({6'd1, 4'd1, 14'd2025}));

      cur_tag = "century";
      set_date(1, 1, 1900);
      chk("leap1900", 32'(bus.leap), 32'd0);
      set_date(1, 1, 2000);
      chk("leap2000", 32'(bus.leap), 32'd1);

      cur_tag = "preload";
      set_date(1, 4, 2023);
      cur_tag = "dec_d_wrap";
      tick(DECD);
      chk("apr30", 32'(bus.day), 32'd30);
      cur_tag = "inc_d_wrap";
      tick(INCD);
      chk("apr1", 32'(bus.day), 32'd1);

      cur_tag = "preload";
      set_date(1, 1, 0);
      cur_tag = "dec_y_wrap";
      tick(DECY);
      chk("year9999", 32'({bus.year, bus.leap}),
          32'({14'd9999, 1'b0}));
      cur_tag = "inc_y_wrap";
      tick(INCY);
      chk("year0", 32'({bus.year, bus.leap}),
          32'({14'd0, 1'b1}));
      cur_tag = "dec_m_wrap";
      tick(DECM);
      chk("month12", 32'(bus.month), 32'd12);

      cur_tag = "preload";
      set_date(31, 1, 2024);
      cur_tag = "clamp_m";
      tick(INCM);
      tick(NONE);
      chk("clamp_feb29", 32'({bus.day, bus.month}),
          32'({6'd29, 4'd2}));

      cur_tag = "preload";
      set_date(31, 1, 2024);
      cur_tag = "clamp_md";
      tick(INCM | INCD);
      tick(NONE);
      chk("clamp_md_feb29", 32'({bus.day, bus.month}),
          32'({6'd29, 4'd2}));

      cur_tag = "incdec";
      set_date(15, 6, 2023);
      tick(INCD | DECD);
      tick(INCM | DECM);
      tick(INCY | DECY);
      chk("incdec_hold",
          32'({bus.day, bus.month, bus.year}),
          32'({6'd15, 4'd6, 14'd2023}));

      cur_tag = "b2b_eod";
      set_date(30, 11, 2023);
      tick(EOD);
      tick(EOD);
      chk("dec2_2023", 32'({bus.day, bus.month}),
          32'({6'd2, 4'd12}));

      cur_tag = "mid_reset";
      set_date(31, 12, 2023);
      drive(EOD);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst",
          32'({bus.day, bus.month, bus.year}),
          32'({6'd1, 4'd1, 14'd2000}));
      drive(NONE);
      @(posedge clk);
      #1;
      rst = 1'b0;
      md = 1;
      mm = 1;
      my = 2000;
      #1;
      chk("after_rst", 32'(obs_date()),
          32'(pack(1, 1, 2000)));
      tick(EOD);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
